// File: rtl/adc_apb_poller_if.sv
// adc_apb_poller_if: bundle between the ADC APB poller and its environment.
//   APB side : PSEL, PENABLE, PWRITE (poller out), PRDATA, PREADY, PSLVERR (ADC out)
//   stream   : smp_data, smp_valid (poller out), smp_ready (consumer out)
//   status   : enable (in to poller), fifo_count, ovf_cnt, err_cnt (poller out)
interface adc_apb_poller_if #(parameter int DEPTH = 8);
  logic                     enable;
  logic                     PSEL;
  logic                     PENABLE;
  logic                     PWRITE;
  logic [31:0]              PRDATA;
  logic                     PREADY;
  logic                     PSLVERR;
  logic [31:0]              smp_data;
  logic                     smp_valid;
  logic                     smp_ready;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic [15:0]              ovf_cnt;
  logic [15:0]              err_cnt;
  modport master (
    input  enable, PRDATA, PREADY, PSLVERR, smp_ready,
    output PSEL, PENABLE, PWRITE, smp_data, smp_valid, fifo_count, ovf_cnt, err_cnt
  );
  modport slave (
    output enable, PRDATA, PREADY, PSLVERR, smp_ready,
    input  PSEL, PENABLE, PWRITE, smp_data, smp_valid, fifo_count, ovf_cnt, err_cnt
  );
endinterface

// File: rtl/adc_apb_poller.sv
// adc_apb_poller: periodic APB read master feeding ADC samples into a show-ahead FIFO stream.
//   PCLK    : clock, rising edge
//   PRESET  : synchronous active-low reset
//   bus     : adc_apb_poller_if.master (APB master, sample stream, enable, status counters)
module adc_apb_poller #(
  parameter int SAMPLE_DIV = 16,
  parameter int MAX_WAIT   = 8,
  parameter int DEPTH      = 8
) (
  input  logic             PCLK,
  input  logic             PRESET,
  adc_apb_poller_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  localparam int WW = MAX_WAIT > 1 ? $clog2(MAX_WAIT) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t        state;
  logic          psel, penable;
  logic [TW-1:0] timer;
  logic [WW-1:0] wait_cnt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic [15:0]   ovf_cnt, err_cnt;
  logic          valid, full, pop, done_ok, done_err, push, ovf;
  assign valid    = count != '0;
  assign full     = count == (AW+1)'(DEPTH);
  assign pop      = valid & bus.smp_ready;
  assign done_ok  = (state == ACCESS) & bus.PREADY & ~bus.PSLVERR;
  // an error ends the transfer either on a PSLVERR response or when the wait budget runs out
  assign done_err = (state == ACCESS) & (bus.PREADY ? bus.PSLVERR : wait_cnt == WW'(MAX_WAIT - 1));
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the sample
  assign push     = done_ok & (~full | pop);
  assign ovf      = done_ok & full & ~pop;
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state    <= IDLE;
      psel     <= 1'b0;
      penable  <= 1'b0;
      timer    <= TW'(SAMPLE_DIV - 1);
      wait_cnt <= '0;
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      ovf_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.enable) begin
          if (timer == '0) begin
            state    <= SETUP;
            psel     <= 1'b1;
            wait_cnt <= '0;
          end else timer <= timer - 1'b1;
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        default: if (done_ok | done_err) begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
          timer   <= TW'(SAMPLE_DIV - 1);
        end else wait_cnt <= wait_cnt + 1'b1;
      endcase
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
      if (ovf && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
      if (done_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
  always_ff @(posedge PCLK) begin
    if (PRESET && push) mem[wp] <= bus.PRDATA;
  end
  assign bus.PSEL       = psel;
  assign bus.PENABLE    = penable;
  assign bus.PWRITE     = 1'b0;
  assign bus.smp_valid  = valid;
  assign bus.smp_data   = valid ? mem[rp] : 32'd0;
  assign bus.fifo_count = count;
  assign bus.ovf_cnt    = ovf_cnt;
  assign bus.err_cnt    = err_cnt;
endmodule

// File: tb/tb_adc_apb_poller.sv
// tb_adc_apb_poller: directed and randomized checks of adc_apb_poller against a queue-based model.
module tb_adc_apb_poller;
  localparam int SD = 4;
  localparam int MW = 8;
  localparam int DP = 8;
  logic PCLK, PRESET;
  int checks = 0, errors = 0;
  adc_apb_poller_if #(.DEPTH(DP)) bus();
  adc_apb_poller #(.SAMPLE_DIV(SD), .MAX_WAIT(MW), .DEPTH(DP)) dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus.master));
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  // model: transfer in progress flag, cycles since PSEL rose, idle cycles left, sample queue
  bit          chk_on = 0;
  bit          m_busy = 0;
  int          m_age = 0, m_left = SD - 1, m_ovf = 0, m_err = 0;
  logic [31:0] q[$];
  always @(negedge PCLK) begin
    bit pop, pushv, fin;
    if (chk_on) begin
      check("PSEL", {31'd0, bus.PSEL}, {31'd0, m_busy});
      check("PENABLE", {31'd0, bus.PENABLE}, {31'd0, m_busy && m_age >= 1});
      check("PWRITE", {31'd0, bus.PWRITE}, 32'd0);
      check("smp_valid", {31'd0, bus.smp_valid}, {31'd0, q.size() > 0});
      check("smp_data", bus.smp_data, q.size() > 0 ? q[0] : 32'd0);
      check("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
      check("ovf_cnt", {16'd0, bus.ovf_cnt}, 32'(m_ovf));
      check("err_cnt", {16'd0, bus.err_cnt}, 32'(m_err));
    end
    if (!PRESET) begin
      chk_on = 1;
      m_busy = 0;
      m_age = 0;
      m_left = SD - 1;
      m_ovf = 0;
      m_err = 0;
      q.delete();
    end else begin
      pop = q.size() > 0 && bus.smp_ready;
      pushv = 0;
      fin = 0;
      if (!m_busy) begin
        if (bus.enable) begin
          if (m_left == 0) begin
            m_busy = 1;
            m_age = 0;
          end else m_left--;
        end
      end else if (m_age == 0) m_age = 1;
      else if (bus.PREADY) begin
        fin = 1;
        if (bus.PSLVERR) m_err = m_err < 65535 ? m_err + 1 : m_err;
        else if (q.size() == DP && !pop) m_ovf = m_ovf < 65535 ? m_ovf + 1 : m_ovf;
        else pushv = 1;
      end else if (m_age == MW) begin
        fin = 1;
        m_err = m_err < 65535 ? m_err + 1 : m_err;
      end else m_age++;
      if (fin) begin
        m_busy = 0;
        m_left = SD - 1;
      end
      if (pop) void'(q.pop_front());
      if (pushv) q.push_back(bus.PRDATA);
    end
  end
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask
  task automatic wait_pen();
    int n = 0;
    while (bus.PSEL && n < 100) begin step(); n++; end
    while (!bus.PENABLE && n < 200) begin step(); n++; end
    if (n >= 200) check("wait_penable", 32'd0, 32'd1);
  endtask
  task automatic do_reset();
    PRESET = 1'b0;
    repeat (2) step();
    PRESET = 1'b1;
  endtask
  task automatic count_access(output int k);
    k = 0;
    while (bus.PENABLE && k < 20) begin k++; step(); end
  endtask
  initial begin
    int n, k, e0;
    bit any;
    PRESET = 1'b0;
    bus.enable = 1'b1;
    bus.PREADY = 1'b1;
    bus.PSLVERR = 1'b0;
    bus.PRDATA = 32'h123;
    bus.smp_ready = 1'b1;
    repeat (3) step();
    PRESET = 1'b1;
    n = 0;
    while (!bus.PSEL && n < 50) begin step(); n++; end
    check("psel_delay", 32'(n), 32'd4);
    step();
    check("penable_high", {31'd0, bus.PENABLE}, 32'd1);
    step();
    check("psel_low", {31'd0, bus.PSEL}, 32'd0);
    check("first_valid", {31'd0, bus.smp_valid}, 32'd1);
    check("first_data", bus.smp_data, 32'h123);
    repeat (12) step();
    check("clean_ovf", {16'd0, bus.ovf_cnt}, 32'd0);
    check("clean_err", {16'd0, bus.err_cnt}, 32'd0);
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'hABC;
    wait_pen();
    k = 0;
    while (bus.PENABLE && k < 20) begin
      k++;
      if (k == 4) bus.PREADY = 1'b1;
      step();
    end
    check("wait3_access_len", 32'(k), 32'd4);
    check("wait3_data", bus.smp_data, 32'hABC);
    check("wait3_err", {16'd0, bus.err_cnt}, 32'd0);
    bus.PREADY = 1'b0;
    e0 = 32'(bus.err_cnt);
    wait_pen();
    count_access(k);
    check("timeout_access_len", 32'(k), 32'd8);
    check("timeout_err", {16'd0, bus.err_cnt}, 32'(e0 + 1));
    check("timeout_count", 32'(bus.fifo_count), 32'd0);
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h55;
    wait_pen();
    step();
    check("after_timeout_count", 32'(bus.fifo_count), 32'd1);
    check("after_timeout_data", bus.smp_data, 32'h55);
    bus.PSLVERR = 1'b1;
    e0 = 32'(bus.err_cnt);
    wait_pen();
    step();
    check("slverr_err", {16'd0, bus.err_cnt}, 32'(e0 + 1));
    check("slverr_nopush", {31'd0, bus.smp_valid}, 32'd0);
    bus.PSLVERR = 1'b0;
    bus.PRDATA = 32'h77;
    wait_pen();
    step();
    check("after_slverr_data", bus.smp_data, 32'h77);
    do_reset();
    bus.smp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.PRDATA = 32'h100 + 32'(i);
      wait_pen();
      step();
    end
    check("full_count", 32'(bus.fifo_count), 32'd8);
    check("full_ovf", {16'd0, bus.ovf_cnt}, 32'd2);
    check("full_head", bus.smp_data, 32'h100);
    bus.PRDATA = 32'h200;
    wait_pen();
    bus.smp_ready = 1'b1;
    step();
    bus.smp_ready = 1'b0;
    check("full_pushpop_ovf", {16'd0, bus.ovf_cnt}, 32'd2);
    check("full_pushpop_count", 32'(bus.fifo_count), 32'd8);
    check("full_pushpop_head", bus.smp_data, 32'h101);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.PRDATA = 32'h300 + 32'(i);
      wait_pen();
      step();
    end
    check("pre_rst_count", 32'(bus.fifo_count), 32'd3);
    bus.PREADY = 1'b0;
    wait_pen();
    PRESET = 1'b0;
    step();
    check("rst_psel", {31'd0, bus.PSEL}, 32'd0);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_valid", {31'd0, bus.smp_valid}, 32'd0);
    check("rst_err", {16'd0, bus.err_cnt}, 32'd0);
    bus.enable = 1'b0;
    bus.PREADY = 1'b1;
    PRESET = 1'b1;
    any = 0;
    repeat (20) begin
      step();
      any |= bus.PSEL;
    end
    check("disabled_psel", {31'd0, any}, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      bus.enable = ($urandom % 8) != 0;
      bus.PREADY = ($urandom % 4) != 0;
      bus.PSLVERR = ($urandom % 10) == 0;
      bus.smp_ready = ($urandom % 2) != 0;
      bus.PRDATA = $urandom;
      PRESET = ($urandom % 400) != 0;
      step();
    end
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
